// File: rtl/id_ex_pkg.sv
// Shared constants and state encoding for the decode/execute boundary register
// and the generic skid register it is built on.
package id_ex_pkg;

  localparam int ID_EX_DW = 32;
  localparam int ID_EX_RW = 5;

  // addi x0,x0,0: what execute sees whenever no bundle is valid
  localparam logic [31:0] INST_NOP = 32'h00000013;

  // Encoding is {main_v, skid_v}
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_BUSY  = 2'b10,
    ST_FULL  = 2'b11
  } skid_state_e;

  function automatic logic skid_has_room(input skid_state_e s);
    return (s != ST_FULL);
  endfunction

endpackage

// File: rtl/id_ex_if.sv
// Decode-side and execute-side handshake plus bundle fields of the id_ex boundary.
interface id_ex_if #(
  parameter int DW = 32,
  parameter int RW = 5
);
  logic          valid_i;
  logic          ready_o;
  logic [DW-1:0] inst_i;
  logic [DW-1:0] inst_addr_i;
  logic [DW-1:0] op1_i;
  logic [DW-1:0] op2_i;
  logic [RW-1:0] rd_addr_i;
  logic          reg_wen_i;
  logic          flush_i;
  logic          valid_o;
  logic          ready_i;
  logic [DW-1:0] inst_o;
  logic [DW-1:0] inst_addr_o;
  logic [DW-1:0] op1_o;
  logic [DW-1:0] op2_o;
  logic [RW-1:0] rd_addr_o;
  logic          reg_wen_o;

  modport slave (
    input  valid_i, inst_i, inst_addr_i, op1_i, op2_i, rd_addr_i, reg_wen_i,
    input  flush_i, ready_i,
    output ready_o, valid_o, inst_o, inst_addr_o, op1_o, op2_o, rd_addr_o, reg_wen_o
  );

  modport master (
    output valid_i, inst_i, inst_addr_i, op1_i, op2_i, rd_addr_i, reg_wen_i,
    output flush_i, ready_i,
    input  ready_o, valid_o, inst_o, inst_addr_o, op1_o, op2_o, rd_addr_o, reg_wen_o
  );
endinterface

// File: rtl/id_ex_pipe_skid_reg.sv
// Generic width-parameterised valid/ready register with a one-entry skid buffer.
// o_ready depends only on registered state, never on i_ready.
module pipe_skid_reg
  import id_ex_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);

  skid_state_e  r_state;
  skid_state_e  w_state_nxt;
  logic [W-1:0] r_main;
  logic [W-1:0] r_skid;
  logic         w_accept;
  logic         w_consume;
  logic         w_load_main;
  logic         w_main_from_skid;
  logic         w_load_skid;

  assign o_ready   = skid_has_room(r_state);
  assign o_valid   = (r_state != ST_EMPTY);
  assign o_data    = r_main;
  assign w_accept  = i_valid & o_ready;
  assign w_consume = o_valid & i_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_EMPTY;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_load_main      = 1'b0;
    w_main_from_skid = 1'b0;
    w_load_skid      = 1'b0;
    // A clear drops both entries and any same-cycle accept
    if (i_clr) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_load_main = 1'b1;
            w_state_nxt = ST_BUSY;
          end
        end
        ST_BUSY: begin
          case ({w_accept, w_consume})
            2'b11: w_load_main = 1'b1;
            2'b01: w_state_nxt = ST_EMPTY;
            2'b10: begin
              w_load_skid = 1'b1;
              w_state_nxt = ST_FULL;
            end
            default: ;
          endcase
        end
        ST_FULL: begin
          if (w_consume) begin
            w_main_from_skid = 1'b1;
            w_state_nxt      = ST_BUSY;
          end
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  // Payload storage needs no reset: it is only observed while its valid bit is set
  always_ff @(posedge clk) begin
    if (w_load_main)           r_main <= i_data;
    else if (w_main_from_skid) r_main <= r_skid;
    if (w_load_skid)           r_skid <= i_data;
  end

endmodule

// File: rtl/id_ex.sv
// Decode-to-execute pipeline boundary: skid-buffered handshake, flush squash,
// and bubble (NOP, no write-back) outputs whenever nothing valid is held.
module id_ex
  import id_ex_pkg::*;
#(
  parameter int            DW       = ID_EX_DW,
  parameter int            RW       = ID_EX_RW,
  parameter logic [DW-1:0] NOP_INST = DW'(INST_NOP)
) (
  input logic     clk,
  input logic     rst,
  id_ex_if.slave  bus
);

  localparam int PW = 4*DW + RW + 1;
  localparam logic [PW-1:0] BUBBLE = {NOP_INST, {(3*DW + RW + 1){1'b0}}};

  logic [PW-1:0] w_payload_in;
  logic [PW-1:0] w_payload_out;
  logic          w_valid;

  assign w_payload_in = {bus.inst_i, bus.inst_addr_i, bus.op1_i, bus.op2_i,
                         bus.rd_addr_i, bus.reg_wen_i};

  pipe_skid_reg #(
    .W (PW)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (bus.flush_i),
    .i_valid (bus.valid_i),
    .o_ready (bus.ready_o),
    .i_data  (w_payload_in),
    .o_valid (w_valid),
    .i_ready (bus.ready_i),
    .o_data  (w_payload_out)
  );

  assign bus.valid_o = w_valid;

  // Execute may ignore valid_o: an empty stage always looks like a NOP
  assign {bus.inst_o, bus.inst_addr_o, bus.op1_o, bus.op2_o,
          bus.rd_addr_o, bus.reg_wen_o} = w_valid ? w_payload_out : BUBBLE;

endmodule
